// File: rtl/four_bit_2x1_mux_pkg.sv
// Shared widths and data type for the 2:1 data selector.
// No logic; imported by the selector stage and the top.
package four_bit_2x1_mux_pkg;
   localparam int DEFAULT_WIDTH     = 4;
   localparam int DEFAULT_CNT_WIDTH = 8;

   typedef logic [DEFAULT_WIDTH-1:0] mux_data_t;
endpackage

// File: rtl/four_bit_2x1_mux_mux2_stage.sv
// Purpose: pure combinational 2:1 selector, out = select ? in_1 : in_0.
// Latency: zero cycles. Backpressure: none, the output always follows the inputs.
module mux2_stage
   import four_bit_2x1_mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_0,
   input  logic             select,
   output logic [WIDTH-1:0] out
);

   // Plain ?: so an X/Z select resolves with the simulator's normal semantics.
   assign out = select ? in_1 : in_0;

endmodule

// File: rtl/four_bit_2x1_mux.sv
// Purpose: 2:1 data selector with a registered copy and a Select-change counter; FOUR_BIT_MUX_PARITY_EN adds Parity.
// Latency: Out is combinational, Out_q/Sel_toggles are one clk behind. Backpressure: none.
module four_bit_2x1_mux
   import four_bit_2x1_mux_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     In_1,
   input  logic [WIDTH-1:0]     In_0,
   input  logic                 Select,
   output logic [WIDTH-1:0]     Out,
   output logic [WIDTH-1:0]     Out_q,
   output logic [CNT_WIDTH-1:0] Sel_toggles
`ifdef FOUR_BIT_MUX_PARITY_EN
   ,
   output logic                 Parity
`endif
);

   logic sel_d;

   mux2_stage #(.WIDTH(WIDTH)) u_mux2_stage (
      .in_1   (In_1),
      .in_0   (In_0),
      .select (Select),
      .out    (Out)
   );

   // sel_d resets to 0, so a Select=1 on the first edge out of reset counts as a toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Out_q       <= '0;
         Sel_toggles <= '0;
         sel_d       <= 1'b0;
      end else begin
         Out_q <= Out;
         sel_d <= Select;
         if ((Select != sel_d) && (Sel_toggles != {CNT_WIDTH{1'b1}}))
            Sel_toggles <= Sel_toggles + CNT_WIDTH'(1);
      end
   end

`ifdef FOUR_BIT_MUX_PARITY_EN
   logic parity_q;

   assign Parity = ^Out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         parity_q <= 1'b0;
      else
         parity_q <= ^Out;
   end
`endif

endmodule

// File: tb/tb_four_bit_2x1_mux.sv
// Randomized scoreboard bench for four_bit_2x1_mux with directed no-clock,
// toggle-count, saturation and async-reset cases.
module tb_four_bit_2x1_mux;
   localparam int W  = 4;
   localparam int CW = 8;

   typedef struct {
      logic [W-1:0]  out;
      logic [W-1:0]  out_q;
      logic [CW-1:0] tog;
      logic          par;
   } exp_t;

   logic          clk = 1'b0;
   logic          clk_en = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in_1, in_0;
   logic          select;
   logic [W-1:0]  out, out_q;
   logic [CW-1:0] sel_toggles;
`ifdef FOUR_BIT_MUX_PARITY_EN
   logic          parity;
`endif

   int n_vec = 0;
   int n_err = 0;
   exp_t sb[$];

   // Reference state: what the spec says the registered view should hold.
   logic [W-1:0] m_out;
   logic [W-1:0] m_q;
   logic         m_prev_sel;
   int           m_changes;

   four_bit_2x1_mux dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .In_1        (in_1),
      .In_0        (in_0),
      .Select      (select),
      .Out         (out),
      .Out_q       (out_q),
      .Sel_toggles (sel_toggles)
`ifdef FOUR_BIT_MUX_PARITY_EN
      ,
      .Parity      (parity)
`endif
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      if (s === 1'b1) return a;
      return b;
   endfunction

   function automatic logic odd_ones(input logic [W-1:0] v);
      int c = 0;
      for (int i = 0; i < W; i++) if (v[i]) c++;
      return (c % 2) == 1;
   endfunction

   function automatic logic [CW-1:0] sat_count(input int c);
      int lim = (1 << CW) - 1;
      return (c > lim) ? CW'(lim) : CW'(c);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: model the edge, then drive new inputs and queue the expected view.
   task automatic cycle(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic rst);
      exp_t e;
      @(posedge clk);
      if (rst_n) begin
         m_q = m_out;
         if (select !== m_prev_sel) m_changes++;
         m_prev_sel = select;
      end
      #1;
      in_1 = a; in_0 = b; select = s; rst_n = rst;
      if (!rst) begin
         m_q = '0; m_changes = 0; m_prev_sel = 1'b0;
      end
      m_out = pick(s, a, b);
      e.out = m_out; e.out_q = m_q; e.tog = sat_count(m_changes); e.par = odd_ones(m_out);
      sb.push_back(e);
   endtask

   task automatic rand_cycle(input logic rst);
      cycle(1'($urandom), 4'($urandom), 4'($urandom), rst);
   endtask

   // Monitor: the DUT presents a result every cycle; compare it on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_out", 32'(out), 32'(e.out));
            check("sb_out_q", 32'(out_q), 32'(e.out_q));
            check("sb_sel_toggles", 32'(sel_toggles), 32'(e.tog));
`ifdef FOUR_BIT_MUX_PARITY_EN
            check("sb_parity", 32'(parity), 32'(e.par));
`endif
         end
      end
   end

   initial begin
      logic [W-1:0] a_tab [3];
      logic [W-1:0] b_tab [3];
      a_tab[0] = 4'b1010; b_tab[0] = 4'b0101;
      a_tab[1] = 4'b1111; b_tab[1] = 4'b0000;
      a_tab[2] = 4'b0011; b_tab[2] = 4'b1100;

      rst_n = 1'b0; select = 1'b0; in_1 = '0; in_0 = '0;
      m_out = '0; m_q = '0; m_prev_sel = 1'b0; m_changes = 0;
      #10;
      check("reset_out_q", 32'(out_q), 32'd0);
      check("reset_sel_toggles", 32'(sel_toggles), 32'd0);

      // Combinational path with no clock and reset held.
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 2; s++) begin
            in_1 = a_tab[k]; in_0 = b_tab[k]; select = 1'(s);
            #10;
            check("comb_no_clk", 32'(out), 32'(s ? a_tab[k] : b_tab[k]));
         end
      end
`ifdef FOUR_BIT_MUX_PARITY_EN
      in_1 = 4'b0111; select = 1'b1; #10;
      check("parity_0111", 32'(parity), 32'd1);
      in_1 = 4'b1010; #10;
      check("parity_1010", 32'(parity), 32'd0);
`endif
      select = 1'b0; in_1 = '0; in_0 = '0;
      m_out = '0;

      clk_en = 1'b1;
      cycle(1'b0, 4'h3, 4'h5, 1'b0);
      cycle(1'b0, 4'h3, 4'h5, 1'b1);
      cycle(1'b1, 4'h9, 4'h6, 1'b1);
      cycle(1'b0, 4'hA, 4'hC, 1'b1);
      cycle(1'b1, 4'h1, 4'hE, 1'b1);
      cycle(1'b1, 4'h7, 4'h2, 1'b1);
      check("toggles_0101", 32'(sel_toggles), 32'd3);

      for (int i = 0; i < 200; i++) rand_cycle(1'b1);

      for (int i = 0; i < 300; i++) cycle(1'(i), 4'($urandom), 4'($urandom), 1'b1);
      check("saturate_255", 32'(sel_toggles), 32'd255);
      for (int i = 0; i < 5; i++) cycle(1'(i), 4'($urandom), 4'($urandom), 1'b1);
      check("saturate_hold", 32'(sel_toggles), 32'd255);

      // Async reset mid-run clears state before the next edge.
      cycle(1'b1, 4'hB, 4'h4, 1'b0);
      #1;
      check("async_rst_toggles", 32'(sel_toggles), 32'd0);
      check("async_rst_out_q", 32'(out_q), 32'd0);
      check("async_rst_out", 32'(out), 32'hB);

      // First edge out of reset with Select=1 counts as one toggle.
      cycle(1'b1, 4'hB, 4'h4, 1'b1);
      cycle(1'b1, 4'h2, 4'h4, 1'b1);
      check("first_edge_toggle", 32'(sel_toggles), 32'd1);

      for (int i = 0; i < 60; i++) rand_cycle(1'b1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
